morse_keyer: RTL and testbench

//  Sequential successor to the combinational Morse lookup. Accepts ASCII characters over a

---
 rtl/morse_keyer.sv | 164 ++++++++++++++++
 tb/tb_morse_keyer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// Morse keyer: accepts ASCII characters over valid/ready and plays them as a timed
// on/off key waveform (dot = 1 unit, dash = DASH_UNITS units, programmable gaps).
module morse_keyer #(
    parameter int CLK_DIV    = 16,
    parameter int DASH_UNITS = 3,
    parameter int SYM_GAP    = 1,
    parameter int CHAR_GAP   = 3,
    parameter int WORD_GAP   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       bad_char
);

    localparam int CW = $clog2(WORD_GAP * CLK_DIV + 1);

    // Counters load N-1 and expire at zero, so a phase of N cycles needs these values.
    localparam logic [CW-1:0] DOT_LD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DASH_LD = CW'(DASH_UNITS * CLK_DIV - 1);
    localparam logic [CW-1:0] SYM_LD  = CW'(SYM_GAP * CLK_DIV - 1);
    localparam logic [CW-1:0] CHAR_LD = CW'(CHAR_GAP * CLK_DIV - 1);
    localparam logic [CW-1:0] WORD_LD = (WORD_GAP == CHAR_GAP) ? '0
                                      : CW'((WORD_GAP - CHAR_GAP) * CLK_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [4:0]    pat;
    logic [2:0]    idx;

    logic       code_ok;
    logic [2:0] code_len;
    logic [4:0] code_pat;
    logic [2:0] first_idx;

    // Returns {supported, len[2:0], pattern[4:0]}; pattern is right-aligned, 1 = dash.
    function automatic logic [8:0] encode(input logic [7:0] c);
        logic [7:0] u;
        logic [8:0] r;
        u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
        r = '0;
        case (u)
            "A": r = {1'b1, 3'd2, 5'b00001};
            "B": r = {1'b1, 3'd4, 5'b01000};
            "C": r = {1'b1, 3'd4, 5'b01010};
            "D": r = {1'b1, 3'd3, 5'b00100};
            "E": r = {1'b1, 3'd1, 5'b00000};
            "F": r = {1'b1, 3'd4, 5'b00010};
            "G": r = {1'b1, 3'd3, 5'b00110};
            "H": r = {1'b1, 3'd4, 5'b00000};
            "I": r = {1'b1, 3'd2, 5'b00000};
            "J": r = {1'b1, 3'd4, 5'b00111};
            "K": r = {1'b1, 3'd3, 5'b00101};
            "L": r = {1'b1, 3'd4, 5'b00100};
            "M": r = {1'b1, 3'd2, 5'b00011};
            "N": r = {1'b1, 3'd2, 5'b00010};
            "O": r = {1'b1, 3'd3, 5'b00111};
            "P": r = {1'b1, 3'd4, 5'b00110};
            "Q": r = {1'b1, 3'd4, 5'b01101};
            "R": r = {1'b1, 3'd3, 5'b00010};
            "S": r = {1'b1, 3'd3, 5'b00000};
            "T": r = {1'b1, 3'd1, 5'b00001};
            "U": r = {1'b1, 3'd3, 5'b00001};
            "V": r = {1'b1, 3'd4, 5'b00001};
            "W": r = {1'b1, 3'd3, 5'b00011};
            "X": r = {1'b1, 3'd4, 5'b01001};
            "Y": r = {1'b1, 3'd4, 5'b01011};
            "Z": r = {1'b1, 3'd4, 5'b01100};
            "0": r = {1'b1, 3'd5, 5'b11111};
            "1": r = {1'b1, 3'd5, 5'b01111};
            "2": r = {1'b1, 3'd5, 5'b00111};
            "3": r = {1'b1, 3'd5, 5'b00011};
            "4": r = {1'b1, 3'd5, 5'b00001};
            "5": r = {1'b1, 3'd5, 5'b00000};
            "6": r = {1'b1, 3'd5, 5'b10000};
            "7": r = {1'b1, 3'd5, 5'b11000};
            "8": r = {1'b1, 3'd5, 5'b11100};
            "9": r = {1'b1, 3'd5, 5'b11110};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign {code_ok, code_len, code_pat} = encode(char_in);
    assign first_idx = code_len - 3'd1;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pat        <= '0;
            idx        <= '0;
            key_out    <= 1'b0;
            char_ready <= 1'b1;
            bad_char   <= 1'b0;
        end else begin
            bad_char <= 1'b0;
            case (state)
                IDLE: begin
                    if (char_valid && char_ready) begin
                        if (char_in == 8'h20) begin
                            state      <= GAP;
                            cnt        <= WORD_LD;
                            char_ready <= 1'b0;
                        end else if (code_ok) begin
                            state      <= MARK;
                            pat        <= code_pat;
                            idx        <= first_idx;
                            cnt        <= code_pat[first_idx] ? DASH_LD : DOT_LD;
                            key_out    <= 1'b1;
                            char_ready <= 1'b0;
                        end else begin
                            bad_char <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (cnt == '0) begin
                        key_out <= 1'b0;
                        if (idx != 3'd0) begin
                            state <= SPACE;
                            idx   <= idx - 3'd1;
                            cnt   <= SYM_LD;
                        end else begin
                            state <= GAP;
                            cnt   <= CHAR_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SPACE: begin
                    if (cnt == '0) begin
                        state   <= MARK;
                        key_out <= 1'b1;
                        cnt     <= pat[idx] ? DASH_LD : DOT_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        char_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer (CLK_DIV=4): key waveforms are captured as run-length
// strings ("H4L12" = 4 cycles on, 12 off) and compared against hand-derived patterns.
module tb_morse_keyer;

    logic       clk;
    logic       rst;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       bad_char;

    int    errors = 0;
    int    checks = 0;
    string rs;
    int    busy_cnt;
    logic  first_bad;
    int    low_run  = 0;
    int    last_low = 0;

    morse_keyer #(
        .CLK_DIV   (4),
        .DASH_UNITS(3),
        .SYM_GAP   (1),
        .CHAR_GAP  (3),
        .WORD_GAP  (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .key_out   (key_out),
        .busy      (busy),
        .bad_char  (bad_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the most recent completed low stretch between two marks.
    always @(negedge clk) begin
        if (rst) begin
            low_run = 0;
        end else if (key_out) begin
            if (low_run > 0) last_low = low_run;
            low_run = 0;
        end else begin
            low_run = low_run + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where char_ready is back high.
    task automatic send(input logic [7:0] c, input bit toggle);
        int   guard;
        logic cur;
        int   n;
        rs       = "";
        busy_cnt = 0;
        cur      = 1'b0;
        n        = 0;
        char_in    = c;
        char_valid = 1'b1;
        guard = 0;
        while (!char_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1 char_valid = 1'b0;
        @(negedge clk);
        first_bad = bad_char;
        guard = 0;
        while (!char_ready && guard < 2000) begin
            if (n > 0 && key_out == cur) begin
                n++;
            end else begin
                if (n > 0) rs = {rs, $sformatf("%s%0d", cur ? "H" : "L", n)};
                cur = key_out;
                n   = 1;
            end
            if (busy) busy_cnt++;
            if (toggle) begin
                char_in    = 8'h45;
                char_valid = !char_valid;
            end
            @(negedge clk);
            guard++;
        end
        char_valid = 1'b0;
        if (n > 0) rs = {rs, $sformatf("%s%0d", cur ? "H" : "L", n)};
        if (guard >= 2000) chk("play_timeout", 1, 0);
    endtask

    initial begin
        rst        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(char_ready), 1);
        chk("rst_key", int'(key_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bad", int'(bad_char), 0);
        rst = 1'b0;
        @(negedge clk);

        send("E", 1'b0);
        chk_s("E_wave", rs, "H4L12");
        chk("E_busy", busy_cnt, 16);
        chk("E_bad", int'(first_bad), 0);

        send("a", 1'b0);
        chk_s("a_wave", rs, "H4L4H12L12");
        chk("a_busy", busy_cnt, 32);
        send("A", 1'b0);
        chk_s("A_wave", rs, "H4L4H12L12");

        // Back-to-back A, space, T: each handshake adds one IDLE cycle, so 12+1+16+1 low.
        send("A", 1'b0);
        chk_s("A2_wave", rs, "H4L4H12L12");
        send(8'h20, 1'b0);
        chk_s("space_wave", rs, "L16");
        chk("space_busy", busy_cnt, 16);
        send("T", 1'b0);
        chk_s("T_wave", rs, "H12L12");
        chk("A_space_T_low", last_low, 30);

        send("0", 1'b0);
        chk_s("0_wave", rs, "H12L4H12L4H12L4H12L4H12L12");
        chk("0_busy", busy_cnt, 88);

        send("#", 1'b0);
        chk("hash_bad", int'(first_bad), 1);
        chk_s("hash_wave", rs, "");
        chk("hash_key", int'(key_out), 0);
        chk("hash_ready", int'(char_ready), 1);
        @(negedge clk);
        chk("hash_bad_clear", int'(bad_char), 0);
        chk("hash_busy", int'(busy), 0);

        send("Q", 1'b1);
        chk_s("Q_toggle_wave", rs, "H12L4H12L4H4L4H12L12");
        chk("Q_ready_after", int'(char_ready), 1);
        chk("Q_busy_after", int'(busy), 0);
        send("9", 1'b0);
        chk_s("9_wave", rs, "H12L4H12L4H12L4H12L4H4L12");

        // Abort a dash with async reset while it is playing.
        char_in    = "T";
        char_valid = 1'b1;
        @(posedge clk);
        #1 char_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_dash_key", int'(key_out), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_key", int'(key_out), 0);
        chk("abort_ready", int'(char_ready), 1);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send("z", 1'b0);
        chk_s("z_wave", rs, "H12L4H12L4H4L4H4L12");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
